// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default latencies for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned DIV_LAT_DEF = 65;
  localparam int unsigned CNT_W       = 7;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  // M is younger than W, so it wins when both hit the same register; x0 never forwards.
  function automatic fwd_sel_t fwd_pick(input creg_addr_t ra,
                                        input logic wenm, input creg_addr_t dstm,
                                        input logic wenw, input creg_addr_t dstw);
    if (wenm && (dstm != '0) && (dstm == ra)) return FWD_M;
    if (wenw && (dstw != '0) && (dstw == ra)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard sequencer signal bundle; master is the datapath side.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  creg_addr_t ra1D, ra2D, dstE, dstM, dstW;
  logic       use1D, use2D;
  logic       wenE, wenM, wenW;
  logic       loadE, muldivE, divE, redirectE;
  logic       ireq_valid, iresp_ok;
  logic       dreq_validM, dresp_okM;

  logic       stallF, stallD, stallE, stallM;
  logic       flushD, flushE, flushM, flushW;
  fwd_sel_t   fwd1D, fwd2D;
  logic       muldiv_start, iresp_accept;

  modport master (
    output ra1D, ra2D, use1D, use2D, dstE, dstM, dstW, wenE, wenM, wenW,
           loadE, muldivE, divE, redirectE, ireq_valid, iresp_ok,
           dreq_validM, dresp_okM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           fwd1D, fwd2D, muldiv_start, iresp_accept
  );

  modport slave (
    input  ra1D, ra2D, use1D, use2D, dstE, dstM, dstW, wenE, wenM, wenW,
           loadE, muldivE, divE, redirectE, ireq_valid, iresp_ok,
           dreq_validM, dresp_okM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
           fwd1D, fwd2D, muldiv_start, iresp_accept
  );
endinterface

// File: rtl/hazard_ctrl_muldiv_seq.sv
// Mul/div start pulse and completion tracking for the instruction parked in E.
module hazard_ctrl_muldiv_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic muldiv,
  input  logic div,
  input  logic stall_e,
  output logic start,
  output logic done
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  assign start = muldiv && (cnt_q == '0) && !done_q;
  assign done  = done_q;

  // done_q survives a memwait stall so the finished result is not restarted.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (start)             cnt_q <= div ? DIV_CNT : MUL_CNT;
      else if (cnt_q != '0)  cnt_q <= cnt_q - 1'b1;

      if (cnt_q == CNT_W'(1)) done_q <= 1'b1;
      else if (!stall_e)      done_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush, forwarding, muldiv sequencing and ibus drop tracking for the F/D/E/M/W core.
//   state  | meaning
//   F_IDLE | no ibus response outstanding
//   F_WAIT | request issued, response still owed and wanted
//   F_DROP | response still owed but fetch was redirected; discard it
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  fetch_state_t state_q, state_d;
  logic memwait, mdbusy, loaduse, fwait, stall_e, redirect_ok;
  logic accept, done_q, md_start;

  hazard_ctrl_muldiv_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_muldiv_seq (
    .clk     (clk),
    .reset   (reset),
    .muldiv  (hz.muldivE),
    .div     (hz.divE),
    .stall_e (stall_e),
    .start   (md_start),
    .done    (done_q)
  );

  assign accept          = hz.iresp_ok && (state_q != F_DROP);
  assign hz.iresp_accept = accept;
  assign hz.muldiv_start = md_start;

  always_ff @(posedge clk) begin
    if (reset) state_q <= F_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      F_IDLE: if (hz.ireq_valid && !hz.iresp_ok) state_d = redirect_ok ? F_DROP : F_WAIT;
      F_WAIT: if (hz.iresp_ok)                   state_d = F_IDLE;
              else if (redirect_ok)              state_d = F_DROP;
      F_DROP: if (hz.iresp_ok)                   state_d = F_IDLE;
      default:                                   state_d = F_IDLE;
    endcase
  end

  // A taken redirect can only occur with E free, so it never fights memwait/mdbusy.
  always_comb begin
    memwait     = hz.dreq_validM && !hz.dresp_okM;
    mdbusy      = hz.muldivE && !done_q;
    loaduse     = hz.loadE && hz.wenE && (hz.dstE != '0) &&
                  ((hz.use1D && (hz.ra1D == hz.dstE)) || (hz.use2D && (hz.ra2D == hz.dstE)));
    fwait       = hz.ireq_valid && !accept;
    stall_e     = memwait || mdbusy;
    redirect_ok = hz.redirectE && !stall_e;

    hz.stallM = memwait;
    hz.stallE = stall_e;
    hz.stallD = !redirect_ok && (stall_e || loaduse);
    hz.stallF = !redirect_ok && (stall_e || loaduse || fwait);
    hz.flushW = memwait;
    hz.flushM = mdbusy && !memwait;
    hz.flushE = redirect_ok || (loaduse && !stall_e);
    hz.flushD = redirect_ok || (fwait && !stall_e && !loaduse);
    hz.fwd1D  = fwd_pick(hz.ra1D, hz.wenM, hz.dstM, hz.wenW, hz.dstW);
    hz.fwd2D  = fwd_pick(hz.ra2D, hz.wenM, hz.dstM, hz.wenW, hz.dstW);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model checked every cycle.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MUL = 3;
  localparam int DIV = 65;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if hz();

  hazard_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // model state: cycles the current mul/div has sat in E; pending/doomed ibus response
  int md_age = 0;
  bit f_pend = 0;
  bit f_doom = 0;

  function automatic logic [1:0] fwd_rule(input logic [4:0] ra, input logic wm, input logic [4:0] dm,
                                          input logic ww, input logic [4:0] dw);
    if (wm && dm != 0 && dm == ra) return 2'd1;
    if (ww && dw != 0 && dw == ra) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge clk) begin : model_cmp
    logic mw, mb, lu, acc, fw, se, tk;
    logic [13:0] exp_v, dut_v;
    int lat;
    lat   = hz.divE ? DIV : MUL;
    mw    = hz.dreq_validM && !hz.dresp_okM;
    mb    = hz.muldivE && (md_age <= lat);
    lu    = hz.loadE && hz.wenE && hz.dstE != 0 &&
            ((hz.use1D && hz.ra1D == hz.dstE) || (hz.use2D && hz.ra2D == hz.dstE));
    acc   = hz.iresp_ok && !f_doom;
    fw    = hz.ireq_valid && !acc;
    se    = mw || mb;
    tk    = hz.redirectE && !se;
    exp_v = {!tk && (se || lu || fw), !tk && (se || lu), se, mw,
             tk || (fw && !se && !lu), tk || (lu && !se), mb && !mw, mw,
             fwd_rule(hz.ra1D, hz.wenM, hz.dstM, hz.wenW, hz.dstW),
             fwd_rule(hz.ra2D, hz.wenM, hz.dstM, hz.wenW, hz.dstW),
             hz.muldivE && md_age == 0, acc};
    dut_v = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE, hz.flushM,
             hz.flushW, hz.fwd1D, hz.fwd2D, hz.muldiv_start, hz.iresp_accept};
    checks++;
    if (dut_v !== exp_v) begin
      errors++;
      $display("FAIL model_cycle t=%0t got %b expected %b (sF sD sE sM fD fE fM fW f1 f2 st acc)",
               $time, dut_v, exp_v);
    end
    if (reset) begin
      md_age = 0; f_pend = 0; f_doom = 0;
    end else begin
      if (!hz.muldivE || !se) md_age = 0;
      else if (md_age < 1000) md_age++;
      if (hz.iresp_ok) begin
        f_pend = 0; f_doom = 0;
      end else begin
        f_doom = f_doom || (tk && (f_pend || hz.ireq_valid));
        f_pend = f_pend || hz.ireq_valid;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic idle();
    hz.ra1D = 0; hz.ra2D = 0; hz.use1D = 0; hz.use2D = 0;
    hz.dstE = 0; hz.dstM = 0; hz.dstW = 0;
    hz.wenE = 0; hz.wenM = 0; hz.wenW = 0;
    hz.loadE = 0; hz.muldivE = 0; hz.divE = 0; hz.redirectE = 0;
    hz.ireq_valid = 0; hz.iresp_ok = 0; hz.dreq_validM = 0; hz.dresp_okM = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic loaduse_setup();
    hz.loadE = 1; hz.wenE = 1; hz.dstE = 5;
    hz.use1D = 1; hz.ra1D = 5; hz.use2D = 1; hz.ra2D = 1;
  endtask

  initial begin
    int n;
    reset = 1;
    idle();
    @(negedge clk);
    chk("rst_stallF", hz.stallF, 0);
    chk("rst_stallE", hz.stallE, 0);
    chk("rst_flushD", hz.flushD, 0);
    chk("rst_fwd1D", hz.fwd1D, 0);
    chk("rst_start", hz.muldiv_start, 0);
    nxt();
    reset = 0;
    nxt();

    // load-use bubble, then forward from M
    loaduse_setup();
    @(negedge clk);
    chk("lu_stallF", hz.stallF, 1);
    chk("lu_stallD", hz.stallD, 1);
    chk("lu_flushE", hz.flushE, 1);
    chk("lu_stallE", hz.stallE, 0);
    nxt();
    hz.loadE = 0; hz.wenE = 0; hz.dstE = 0; hz.wenM = 1; hz.dstM = 5;
    @(negedge clk);
    chk("lu_fwd1D", hz.fwd1D, 1);
    chk("lu_fwd2D", hz.fwd2D, 0);
    chk("lu_after_stallF", hz.stallF, 0);
    nxt();
    idle();

    // mul in E with redirect pending: redirect only honoured once E frees
    hz.muldivE = 1; hz.redirectE = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("mul_start_%0d", i), hz.muldiv_start, (i == 0) ? 1 : 0);
      chk($sformatf("mul_stallE_%0d", i), hz.stallE, (i < 4) ? 1 : 0);
      chk($sformatf("mul_flushM_%0d", i), hz.flushM, (i < 4) ? 1 : 0);
      chk($sformatf("mul_flushE_%0d", i), hz.flushE, (i == 4) ? 1 : 0);
      nxt();
    end
    idle();
    nxt();

    // ibus wait with redirect in the first wait cycle -> response dropped
    hz.ireq_valid = 1; hz.redirectE = 1;
    @(negedge clk);
    chk("drop_flushD0", hz.flushD, 1);
    chk("drop_flushE0", hz.flushE, 1);
    chk("drop_stallF0", hz.stallF, 0);
    nxt();
    hz.redirectE = 0;
    @(negedge clk);
    chk("drop_stallF1", hz.stallF, 1);
    nxt();
    hz.iresp_ok = 1;
    @(negedge clk);
    chk("drop_accept", hz.iresp_accept, 0);
    chk("drop_stallF2", hz.stallF, 1);
    nxt();
    @(negedge clk);
    chk("refetch_accept", hz.iresp_accept, 1);
    chk("refetch_stallF", hz.stallF, 0);
    nxt();
    idle();

    // dbus wait overlapping load-use
    hz.dreq_validM = 1;
    loaduse_setup();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mw_stall_%0d", i), {hz.stallF, hz.stallD, hz.stallE, hz.stallM}, 4'hF);
      chk($sformatf("mw_flushE_%0d", i), hz.flushE, 0);
      chk($sformatf("mw_flushW_%0d", i), hz.flushW, 1);
      nxt();
    end
    hz.dresp_okM = 1;
    @(negedge clk);
    chk("mw_end_stallM", hz.stallM, 0);
    chk("mw_end_stallD", hz.stallD, 1);
    chk("mw_end_flushE", hz.flushE, 1);
    nxt();
    idle();

    // forwarding priority and x0
    hz.wenM = 1; hz.dstM = 3; hz.wenW = 1; hz.dstW = 3; hz.ra1D = 3; hz.ra2D = 7;
    @(negedge clk);
    chk("fwd_m", hz.fwd1D, 1);
    chk("fwd_other", hz.fwd2D, 0);
    nxt();
    hz.dstM = 0;
    @(negedge clk);
    chk("fwd_w", hz.fwd1D, 2);
    nxt();
    hz.dstW = 0;
    @(negedge clk);
    chk("fwd_rf", hz.fwd1D, 0);
    nxt();
    hz.ra1D = 0; hz.ra2D = 3; hz.dstW = 3; hz.wenM = 0; hz.dstM = 3;
    @(negedge clk);
    chk("fwd_x0", hz.fwd1D, 0);
    chk("fwd_wenM_off", hz.fwd2D, 2);
    nxt();
    idle();

    // memwait during mul countdown: done holds, E released as soon as dbus answers
    hz.muldivE = 1; hz.dreq_validM = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("mdmw_flushM_%0d", i), hz.flushM, 0);
      chk($sformatf("mdmw_stallE_%0d", i), hz.stallE, 1);
      nxt();
    end
    hz.dresp_okM = 1;
    @(negedge clk);
    chk("mdmw_release", hz.stallE, 0);
    nxt();
    idle();

    // reset mid-countdown abandons the sequence
    hz.muldivE = 1;
    @(negedge clk);
    chk("rst_md_start", hz.muldiv_start, 1);
    nxt();
    nxt();
    reset = 1;
    @(negedge clk);
    chk("rst_md_nostart", hz.muldiv_start, 0);
    nxt();
    reset = 0; hz.muldivE = 0;
    @(negedge clk);
    chk("rst_md_stallE", hz.stallE, 0);
    chk("rst_md_flushM", hz.flushM, 0);
    nxt();
    hz.muldivE = 1;
    @(negedge clk);
    chk("rst_md_fresh", hz.muldiv_start, 1);
    for (int i = 0; i < 4; i++) nxt();
    idle();
    nxt();

    // reset while in drop state: next response accepted
    hz.ireq_valid = 1; hz.redirectE = 1;
    nxt();
    hz.redirectE = 0; reset = 1;
    nxt();
    reset = 0; hz.iresp_ok = 1;
    @(negedge clk);
    chk("rst_drop_accept", hz.iresp_accept, 1);
    nxt();
    idle();

    // divide occupies E for DIV+1 stalled cycles
    hz.muldivE = 1; hz.divE = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hz.stallE !== 1'b1) break;
      n++;
      nxt();
    end
    chk("div_stall_cycles", 8'(n), 8'(DIV + 1));
    nxt();
    idle();
    nxt();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
